// File: rtl/cam_rr_mux.sv
// -----------------------------------------------------------------------------
// cam_rr_mux -- N-channel round-robin multiplexer with a one-word output register
//
// Each cycle with a free (or freeing) output slot, the arbiter picks the first
// valid channel after the last-granted one. It accepts that channel's word
// through in_ready and registers it on the output one cycle later.
//
// Parameters
//   N      number of input channels (1..16)
//   WIDTH  data width per channel
//   SW     select width, max(1, clog2(N))
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   in_valid   [N]        per-channel request
//   in_data    [N*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_ready   [N]        one-hot (or zero) accept for the granted channel
//   out_valid             output register holds a word
//   out_data   [WIDTH]    registered word
//   out_sel    [SW]       channel that supplied out_data
//   out_ready             downstream accept
//   force_en, force_sel   only with CAM_RR_MUX_FORCE_EN: restrict the grant to
//                         channel force_sel without moving the round-robin pointer
//
// Optional feature macro: CAM_RR_MUX_FORCE_EN
// -----------------------------------------------------------------------------

// Per-lane data gate: passes the lane's word only when that lane is granted,
// so the output mux reduces to an OR across lanes.
module cam_rr_mux_lane #(
   parameter int WIDTH = 32
) (
   input  logic             gnt,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] data_m
);
   assign data_m = {WIDTH{gnt}} & data;
endmodule

module cam_rr_mux #(
   parameter  int N     = 4,
   parameter  int WIDTH = 32,
   localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SW-1:0]      out_sel,
`ifdef CAM_RR_MUX_FORCE_EN
   input  logic               force_en,
   input  logic [SW-1:0]      force_sel,
`endif
   input  logic               out_ready
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [SW-1:0]           ptr_q;
   logic [SW-1:0]           gnt_idx;
   logic [SW-1:0]           sel_q;
   logic [WIDTH-1:0]        data_q;
   logic [N-1:0]            cand;
   logic [N-1:0]            gnt_oh;
   logic                    found;
   logic                    load;
   logic                    take;
   logic                    ptr_upd;
   logic [N-1:0][WIDTH-1:0] lane_data;
   logic [WIDTH-1:0]        mux_data;

   // Candidate set. A forced grant looks at one channel only; an out-of-range
   // force_sel matches no channel and so grants nothing.
`ifdef CAM_RR_MUX_FORCE_EN
   always_comb begin
      cand    = in_valid;
      ptr_upd = 1'b1;
      if (force_en) begin
         cand    = '0;
         ptr_upd = 1'b0;
         for (int i = 0; i < N; i++)
            if (int'(force_sel) == i) cand[i] = in_valid[i];
      end
   end
`else
   assign cand    = in_valid;
   assign ptr_upd = 1'b1;
`endif

   // Round-robin search starting at ptr+1. Distances are scanned from far to
   // near, so the nearest valid channel is the last one written and wins.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = N; k >= 1; k--)
         for (int i = 0; i < N; i++)
            if (cand[i] && (((int'(ptr_q) + k) % N) == i)) begin
               found   = 1'b1;
               gnt_idx = SW'(i);
            end
   end

   assign load = (state_q == EMPTY) | out_ready;
   // Reset suppresses the handshake so that nothing is accepted in the reset cycle.
   assign take = load & found & ~reset;

   always_comb begin
      gnt_oh = '0;
      for (int i = 0; i < N; i++)
         gnt_oh[i] = take && (gnt_idx == SW'(i));
   end

   assign in_ready = gnt_oh;

   for (genvar g = 0; g < N; g++) begin : g_lane
      cam_rr_mux_lane #(.WIDTH(WIDTH)) u_lane (
         .gnt    (gnt_oh[g]),
         .data   (in_data[g*WIDTH +: WIDTH]),
         .data_m (lane_data[g])
      );
   end

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N; i++) mux_data = mux_data | lane_data[i];
   end

   // Next state: any load slot either refills the register or empties it.
   always_comb begin
      state_d = state_q;
      if (load) state_d = found ? FULL : EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= SW'(N-1);     // channel 0 searched first after reset
      end else begin
         state_q <= state_d;
         if (take) begin
            data_q <= mux_data;
            sel_q  <= gnt_idx;
            if (ptr_upd) ptr_q <= gnt_idx;
         end
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule

// File: doc/cam_rr_mux.md
CAM_RR_MUX -- requirements
Module: cam_rr_mux

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels; legal range 1..16.
REQ-002 SHALL have parameter WIDTH, default 32: data width per channel.
REQ-003 SHALL have localparam SW = max(1, clog2(N)): select/index width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  N: per-channel request valid.
REQ-007 SHALL have port in_data  input  N*WIDTH: channel i data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_ready  output  N: per-channel accept; one-hot or zero.
REQ-009 SHALL have port out_valid  output  1: output register holds a word.
REQ-010 SHALL have port out_data  output  WIDTH: registered selected word.
REQ-011 SHALL have port out_sel  output  SW: index of the channel that supplied out_data.
REQ-012 SHALL have port out_ready  input  1: downstream accept.

Function
REQ-013 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 SHALL define load = (state==EMPTY) | out_ready; a load slot exists only when load=1.
REQ-015 SHALL grant, when load=1, the first channel with in_valid=1 searching ptr+1, ptr+2, ... mod N, where ptr is the last-granted index.
REQ-016 SHALL drive in_ready[g]=1 combinationally for the granted channel g only; in_ready=0 when load=0 or no in_valid.
REQ-017 SHALL, on a cycle with a grant, register out_data<=in_data[g], out_sel<=g, ptr<=g, state<=FULL; latency in->out is 1 cycle.
REQ-018 SHALL transition FULL->EMPTY when out_ready=1 and no grant; FULL->FULL with new data when out_ready=1 and a grant exists (back-to-back, 1 word/cycle).
REQ-019 SHALL hold out_data, out_sel and ptr stable while FULL and out_ready=0.
REQ-020 SHALL not update ptr on cycles without a grant.
REQ-021 SHALL, with all N channels continuously valid and out_ready=1, grant 0,1,...,N-1,0,... (wrap-around from N-1 to 0).
REQ-022 SHALL, for N=1, behave as a one-deep registered pipeline stage with out_sel constant 0.
REQ-023 SHALL ignore in_data of non-granted channels; in_valid deasserting without handshake is permitted and not an error.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, set state=EMPTY, out_valid=0, out_data=0, out_sel=0, ptr=N-1 (channel 0 has first priority).
REQ-025 SHALL force in_ready=0 during any cycle with reset=1.
REQ-026 SHALL discard any held word on reset mid-operation; no handshake completes in the reset cycle.

Configuration
REQ-027 SHALL, when macro CAM_RR_MUX_FORCE_EN is defined, add ports force_en (input 1) and force_sel (input SW).
REQ-028 SHALL, with CAM_RR_MUX_FORCE_EN defined and force_en=1, consider only channel force_sel for grant, leave ptr unchanged, and keep in_ready of all other channels at 0; force_sel>=N grants nothing.
REQ-029 SHALL, without CAM_RR_MUX_FORCE_EN, omit both ports and perform pure round-robin per REQ-015.

Verification
REQ-030 SHALL cover: reset, then in_valid=4'b0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_sel=2.
REQ-031 SHALL cover: all four valid, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3.
REQ-032 SHALL cover: FULL with out_sel=1, out_ready=0 for 5 cycles, in_valid=4'b1111 -> in_ready=0, out_data/out_sel unchanged; on out_ready=1 next grant is channel 2.
REQ-033 SHALL cover: reset asserted while FULL with channel 3 pending -> next cycle out_valid=0, out_sel=0; first grant afterwards with in_valid=4'b1001 is channel 0.
REQ-034 SHALL cover: out_ready=1, in_valid=0 while FULL -> out_valid=0 next cycle; in_valid=4'b0001 arriving in EMPTY -> out_valid=1 one cycle later.
REQ-035 SHALL cover, with CAM_RR_MUX_FORCE_EN: force_en=1, force_sel=3, in_valid=4'b1111 for 3 cycles -> out_sel=3 each word, ptr unchanged; force_en=0 afterwards resumes from previous ptr.
